// File: rtl/usb_rx_bit_sequencer.sv
// rtl/usb_rx_bit_sequencer.sv - USB receive bit sequencer: SYNC hunt, bit unstuffing, byte FIFO, EOP framing
//
// Purpose: sits between NRZI decode and the packet layer. It hunts for SYNC,
// strips stuffed zeros, packs LSB-first bytes into a small FIFO and frames each
// packet on EOP with sticky error status.
//
// Ports:
//   clk12        in   12 MHz bit clock
//   RST_N        in   asynchronous active-low reset
//   bitIn        in   decoded data bit
//   bitValid     in   bitIn/eopIn valid this cycle
//   eopIn        in   end of packet (sampled only with bitValid)
//   rxByte       out  [7:0] FIFO head byte (registered)
//   rxByteValid  out  FIFO non-empty
//   rxByteReady  in   consumer pops the head when valid & ready
//   rxActive     out  packet in progress (SYNC accepted .. EOP)
//   packetDone   out  one-cycle pulse at EOP
//   errStuff     out  sticky: seventh consecutive 1
//   errAlign     out  sticky: EOP with a partial byte
//   errOverflow  out  sticky: byte completed while the FIFO was full
module usb_rx_bit_sequencer #(
  parameter int SYNC_ZEROS = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk12,
  input  logic       RST_N,
  input  logic       bitIn,
  input  logic       bitValid,
  input  logic       eopIn,
  output logic [7:0] rxByte,
  output logic       rxByteValid,
  input  logic       rxByteReady,
  output logic       rxActive,
  output logic       packetDone,
  output logic       errStuff,
  output logic       errAlign,
  output logic       errOverflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [2:0]    SYNC_Z   = 3'(SYNC_ZEROS);

  typedef enum logic [1:0] {HUNT, DATA, DRAIN} state_t;

  state_t        state;
  logic [2:0]    zeroRun;
  logic [2:0]    oneCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          pushPend;
  logic [7:0]    pushData;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;

  logic          pop;
  logic          pushOk;
  logic [AW-1:0] rdNxt;
  logic [CW-1:0] countNxt;
  logic [7:0]    headNxt;

  assign rxByteValid = (count != '0);

  // A pending byte is accepted when there is room, counting a same-cycle pop.
  always_comb begin
    pop    = rxByteValid & rxByteReady;
    pushOk = pushPend & ((count != FULL_CNT) | pop);
    rdNxt  = pop ? rdPtr + AW'(1) : rdPtr;
    case ({pushOk, pop})
      2'b10:   countNxt = count + CW'(1);
      2'b01:   countNxt = count - CW'(1);
      default: countNxt = count;
    endcase
    // The new head is the byte being written when it lands in the head slot.
    headNxt = (pushOk && (rdNxt == wrPtr)) ? pushData : mem[rdNxt];
  end

  always_ff @(posedge clk12) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk12 or negedge RST_N) begin
    if (!RST_N) begin
      state       <= HUNT;
      zeroRun     <= '0;
      oneCnt      <= '0;
      bitCnt      <= '0;
      shiftReg    <= '0;
      pushPend    <= 1'b0;
      pushData    <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      rxByte      <= '0;
      rxActive    <= 1'b0;
      packetDone  <= 1'b0;
      errStuff    <= 1'b0;
      errAlign    <= 1'b0;
      errOverflow <= 1'b0;
    end else begin
      packetDone <= 1'b0;
      pushPend   <= 1'b0;

      // FIFO runs every cycle, independent of bitValid.
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      rdPtr <= rdNxt;
      count <= countNxt;
      if (countNxt != '0) rxByte <= headNxt;
      if (pushPend && !pushOk) errOverflow <= 1'b1;

      if (bitValid) begin
        case (state)
          HUNT: begin
            if (!eopIn) begin
              if (!bitIn) begin
                if (zeroRun != 3'd7) zeroRun <= zeroRun + 3'd1;
              end else begin
                zeroRun <= '0;
                if (zeroRun >= SYNC_Z) begin
                  state       <= DATA;
                  rxActive    <= 1'b1;
                  oneCnt      <= 3'd1;  // SYNC's final 1 starts the stuffing run
                  bitCnt      <= '0;
                  errStuff    <= 1'b0;
                  errAlign    <= 1'b0;
                  errOverflow <= 1'b0;
                end
              end
            end
          end
          DATA: begin
            if (eopIn) begin
              packetDone <= 1'b1;
              rxActive   <= 1'b0;
              errAlign   <= (bitCnt != '0);
              state      <= HUNT;
            end else if (oneCnt == 3'd6) begin
              if (!bitIn) begin
                oneCnt <= '0;
              end else begin
                errStuff <= 1'b1;
                state    <= DRAIN;
              end
            end else begin
              shiftReg <= {bitIn, shiftReg[7:1]};
              bitCnt   <= bitCnt + 3'd1;
              oneCnt   <= bitIn ? oneCnt + 3'd1 : 3'd0;
              if (bitCnt == 3'd7) begin
                pushPend <= 1'b1;
                pushData <= {bitIn, shiftReg[7:1]};
              end
            end
          end
          DRAIN: begin
            if (eopIn) begin
              packetDone <= 1'b1;
              rxActive   <= 1'b0;
              state      <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_sequencer.sv
// tb/tb_usb_rx_bit_sequencer.sv - self-checking bench for usb_rx_bit_sequencer
module tb_usb_rx_bit_sequencer;

  localparam int SYNC_ZEROS = 6;
  localparam int FIFO_DEPTH = 2;

  logic       clk12 = 1'b0;
  logic       RST_N = 1'b0;
  logic       bitIn = 1'b0;
  logic       bitValid = 1'b0;
  logic       eopIn = 1'b0;
  logic [7:0] rxByte;
  logic       rxByteValid;
  logic       rxByteReady = 1'b1;
  logic       rxActive;
  logic       packetDone;
  logic       errStuff;
  logic       errAlign;
  logic       errOverflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int gap_max = 0;
  logic [7:0] got[$];
  logic       pb[$];

  usb_rx_bit_sequencer #(.SYNC_ZEROS(SYNC_ZEROS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk12(clk12), .RST_N(RST_N), .bitIn(bitIn), .bitValid(bitValid), .eopIn(eopIn),
    .rxByte(rxByte), .rxByteValid(rxByteValid), .rxByteReady(rxByteReady),
    .rxActive(rxActive), .packetDone(packetDone), .errStuff(errStuff),
    .errAlign(errAlign), .errOverflow(errOverflow)
  );

  always #5 clk12 = ~clk12;

  // Inputs change 1 time unit after posedge, so the negedge view is stable.
  always @(negedge clk12) begin
    if (RST_N) begin
      if (rxByteValid && rxByteReady) got.push_back(rxByte);
      if (packetDone) done_cnt++;
    end
  end

  function automatic int rgap();
    return (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
  endfunction

  task automatic send_bit(input logic b, input logic e, input int gap);
    bitIn = b; eopIn = e; bitValid = 1'b1;
    @(posedge clk12); #1;
    bitValid = 1'b0; bitIn = 1'($urandom); eopIn = 1'($urandom);
    repeat (gap) begin @(posedge clk12); #1; end
  endtask

  task automatic send_sync(input int nz);
    repeat (nz) send_bit(1'b0, 1'b0, rgap());
    send_bit(1'b1, 1'b0, rgap());
  endtask

  // Reference encoder: LSB-first bytes plus trailing bits, a 0 inserted after
  // every run of six 1s, the run starting at 1 because of the SYNC's last bit.
  task automatic encode(input logic [7:0] data[$], input int extra);
    logic raw[$];
    int ones;
    raw.delete(); pb.delete();
    foreach (data[k]) for (int i = 0; i < 8; i++) raw.push_back(data[k][i]);
    for (int i = 0; i < extra; i++) raw.push_back(1'($urandom));
    ones = 1;
    foreach (raw[i]) begin
      pb.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin pb.push_back(1'b0); ones = 0; end
    end
  endtask

  task automatic send_stream();
    foreach (pb[i]) send_bit(pb[i], 1'b0, rgap());
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk12); #1; end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rxByte !== 8'h00) begin errors++; $display("FAIL reset_rxByte got %h exp 00", rxByte); end
    checks++; if (rxByteValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rxByteValid); end
    checks++; if (rxActive !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", rxActive); end
    checks++; if (packetDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", packetDone); end
    checks++; if ({errStuff, errAlign, errOverflow} !== 3'b000) begin errors++; $display("FAIL reset_err got %b exp 000", {errStuff, errAlign, errOverflow}); end
    @(posedge clk12); #1; RST_N = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    logic [7:0] d[$];
    int d0;
    gap_max = 0; rxByteReady = 1'b1; got.delete(); d0 = done_cnt;
    repeat (7) send_bit(1'b0, 1'b0, 0);
    checks++; if (rxActive !== 1'b0) begin errors++; $display("FAIL basic_active_pre got %b exp 0", rxActive); end
    send_bit(1'b1, 1'b0, 0);
    checks++; if (rxActive !== 1'b1) begin errors++; $display("FAIL basic_active_sync got %b exp 1", rxActive); end
    d = '{8'hA5, 8'h3C};
    encode(d, 0);
    send_stream();
    checks++; if (rxByteValid !== 1'b0) begin errors++; $display("FAIL latency_n1 got %b exp 0", rxByteValid); end
    @(posedge clk12); #1;
    checks++; if (rxByteValid !== 1'b1 || rxByte !== 8'h3C) begin errors++; $display("FAIL latency_n2 got %b/%h exp 1/3c", rxByteValid, rxByte); end
    send_bit(1'b0, 1'b1, 0);
    idle(6);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL basic_count got %0d exp 2", got.size()); end
    else foreach (d[i]) begin checks++; if (got[i] !== d[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, got[i], d[i]); end end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt - d0); end
    checks++; if ({errStuff, errAlign, errOverflow, rxActive} !== 4'b0000) begin errors++; $display("FAIL basic_flags got %b exp 0000", {errStuff, errAlign, errOverflow, rxActive}); end
  endtask

  task automatic test_stuff();
    logic b[$];
    gap_max = 1; got.delete();
    send_sync(SYNC_ZEROS);
    b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (b[i]) send_bit(b[i], 1'b0, rgap());
    send_bit(1'b0, 1'b1, 0);
    idle(6);
    checks++; if (got.size() != 1 || got[0] !== 8'h7F) begin errors++; $display("FAIL stuff_byte got n=%0d %h exp 7f", got.size(), (got.size() > 0) ? got[0] : 8'h00); end
    checks++; if ({errStuff, errAlign} !== 2'b00) begin errors++; $display("FAIL stuff_flags got %b exp 00", {errStuff, errAlign}); end
  endtask

  task automatic test_stuff_error();
    int d0;
    gap_max = 1; got.delete(); d0 = done_cnt;
    send_sync(SYNC_ZEROS);
    repeat (5) send_bit(1'b1, 1'b0, rgap());
    send_bit(1'b1, 1'b0, 0);
    checks++; if (errStuff !== 1'b1 || rxActive !== 1'b1) begin errors++; $display("FAIL stufferr_set got %b%b exp 11", errStuff, rxActive); end
    repeat (10) send_bit(1'($urandom), 1'b0, rgap());
    send_bit(1'b0, 1'b1, 0);
    idle(6);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL stufferr_bytes got %0d exp 0", got.size()); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stufferr_done got %0d exp 1", done_cnt - d0); end
    checks++; if ({errStuff, errAlign, rxActive} !== 3'b100) begin errors++; $display("FAIL stufferr_flags got %b exp 100", {errStuff, errAlign, rxActive}); end
  endtask

  task automatic test_align();
    logic [7:0] d[$];
    int d0;
    gap_max = 2; got.delete(); d0 = done_cnt;
    send_sync(SYNC_ZEROS + 1);
    d = '{8'h55};
    encode(d, 3);
    send_stream();
    send_bit(1'b0, 1'b1, 0);
    idle(6);
    checks++; if (got.size() != 1 || got[0] !== 8'h55) begin errors++; $display("FAIL align_byte got n=%0d exp 55", got.size()); end
    checks++; if (errAlign !== 1'b1 || errStuff !== 1'b0) begin errors++; $display("FAIL align_flag got %b%b exp 10", errAlign, errStuff); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL align_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_overflow();
    logic [7:0] d[$];
    gap_max = 0; got.delete(); rxByteReady = 1'b0;
    send_sync(SYNC_ZEROS);
    d = '{8'h01, 8'h02, 8'h03};
    encode(d, 0);
    send_stream();
    send_bit(1'b0, 1'b1, 0);
    idle(4);
    checks++; if (rxByteValid !== 1'b1 || rxByte !== 8'h01) begin errors++; $display("FAIL ovf_head got %b/%h exp 1/01", rxByteValid, rxByte); end
    checks++; if (errOverflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", errOverflow); end
    rxByteReady = 1'b1;
    idle(6);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL ovf_count got %0d exp 2", got.size()); end
    else begin
      checks++; if (got[0] !== 8'h01 || got[1] !== 8'h02) begin errors++; $display("FAIL ovf_bytes got %h %h exp 01 02", got[0], got[1]); end
    end
    checks++; if (rxByteValid !== 1'b0 || errOverflow !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b%b exp 01", rxByteValid, errOverflow); end
  endtask

  task automatic test_short_sync();
    int d0;
    gap_max = 1; got.delete(); d0 = done_cnt;
    send_sync(4);
    checks++; if (rxActive !== 1'b0) begin errors++; $display("FAIL short4_active got %b exp 0", rxActive); end
    send_sync(SYNC_ZEROS - 1);
    checks++; if (rxActive !== 1'b0) begin errors++; $display("FAIL short5_active got %b exp 0", rxActive); end
    send_bit(1'b0, 1'b1, 0);
    idle(3);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL hunt_eop_done got %0d exp %0d", done_cnt, d0); end
    send_sync(SYNC_ZEROS);
    checks++; if (rxActive !== 1'b1) begin errors++; $display("FAIL exact_sync_active got %b exp 1", rxActive); end
    send_bit(1'b0, 1'b1, 0);
    idle(3);
  endtask

  task automatic test_random_packets();
    logic [7:0] d[$];
    int n, extra, d0;
    gap_max = 2; rxByteReady = 1'b1;
    for (int p = 0; p < 12; p++) begin
      got.delete(); d.delete(); d0 = done_cnt;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) d.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      extra = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
      send_sync(int'($urandom_range(SYNC_ZEROS, 9)));
      encode(d, extra);
      send_stream();
      send_bit(1'b0, 1'b1, 0);
      idle(6);
      checks++; if (got.size() != d.size()) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", p, got.size(), d.size()); end
      else foreach (d[i]) begin checks++; if (got[i] !== d[i]) begin errors++; $display("FAIL rnd%0d_byte%0d got %h exp %h", p, i, got[i], d[i]); end end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rnd%0d_done got %0d exp 1", p, done_cnt - d0); end
      checks++; if ({errStuff, errAlign, errOverflow, rxActive} !== {1'b0, extra != 0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL rnd%0d_flags got %b exp %b", p, {errStuff, errAlign, errOverflow, rxActive}, {1'b0, extra != 0, 2'b00});
      end
    end
  endtask

  task automatic test_midreset();
    logic [7:0] d[$];
    int d0;
    gap_max = 0; got.delete(); rxByteReady = 1'b0; d0 = done_cnt;
    send_sync(SYNC_ZEROS);
    d = '{8'hC3};
    encode(d, 4);
    send_stream();
    idle(2);
    checks++; if (rxByteValid !== 1'b1 || rxActive !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b%b exp 11", rxByteValid, rxActive); end
    #2; RST_N = 1'b0; #1;
    checks++; if ({rxByteValid, rxActive, packetDone, errStuff, errAlign, errOverflow} !== 6'b0 || rxByte !== 8'h00) begin
      errors++; $display("FAIL midrst_async got %b/%h exp 000000/00", {rxByteValid, rxActive, packetDone, errStuff, errAlign, errOverflow}, rxByte);
    end
    idle(2);
    RST_N = 1'b1; rxByteReady = 1'b1;
    idle(4);
    checks++; if (done_cnt != d0 || got.size() != 0 || rxByteValid !== 1'b0) begin errors++; $display("FAIL midrst_post got done=%0d n=%0d exp done=%0d n=0", done_cnt, got.size(), d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_stuff_error();
    test_align();
    test_overflow();
    test_short_sync();
    test_random_packets();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
